// File: rtl/fir_datapath_ctrl_if.sv
// Stream channel used on both sides of the FIR engine: valid/data/last forward, ready back.
interface fir_datapath_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tready;

    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/fir_datapath_ctrl.sv
// Sample-by-sample FIR engine: stores each input in a circular history BRAM, walks the taps
// through 1-cycle-latency tap/data BRAM reads, multiply-accumulates and streams y[n] out.
module fir_datapath_ctrl #(
    parameter int NUM_TAP = 11,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12
) (
    input  logic                axis_clk,
    input  logic                axis_rst_n,
    input  logic                ap_start,
    input  logic [31:0]         data_length,
    output logic                ap_idle,
    output logic                ap_done,
    output logic                err_tlast,
    fir_datapath_ctrl_if.slave  ss,
    fir_datapath_ctrl_if.master sm,
    output logic                tap_EN,
    output logic [ADDR_W-1:0]   tap_A,
    input  logic [DATA_W-1:0]   tap_Do,
    output logic                data_EN,
    output logic [3:0]          data_WE,
    output logic [ADDR_W-1:0]   data_A,
    output logic [DATA_W-1:0]   data_Di,
    input  logic [DATA_W-1:0]   data_Do
);
    localparam int IDX_W = $clog2(NUM_TAP + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAP - 1);
    localparam logic [IDX_W-1:0] MAC_END  = IDX_W'(NUM_TAP);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT} state_t;

    state_t            state, state_nxt;
    logic [31:0]       len;
    logic [31:0]       count;
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  hist_idx;
    logic [DATA_W-1:0] acc;
    logic              is_last;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
        return ADDR_W'({idx, 2'b00});
    endfunction

    assign is_last  = (count == len - 32'd1);
    // Word holding x[n-k]; modular IDX_W arithmetic keeps the wrap branch exact.
    assign hist_idx = (head >= k) ? head - k : head + MAC_END - k;
    assign ap_idle  = (state == S_IDLE);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_nxt = state;
        ss.tready = 1'b0;
        sm.tvalid = 1'b0;
        sm.tdata  = '0;
        sm.tlast  = 1'b0;
        tap_EN    = 1'b0;
        tap_A     = '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_Di   = '0;
        unique case (state)
            S_IDLE: begin
                if (ap_start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(k);
                if (k == LAST_IDX) state_nxt = (len == 32'd0) ? S_IDLE : S_WAIT_IN;
            end
            S_WAIT_IN: begin
                ss.tready = 1'b1;
                if (ss.tvalid) begin
                    data_EN   = 1'b1;
                    data_WE   = 4'hF;
                    data_A    = word_addr(head);
                    data_Di   = ss.tdata;
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (k != MAC_END) begin
                    tap_EN  = 1'b1;
                    tap_A   = word_addr(k);
                    data_EN = 1'b1;
                    data_A  = word_addr(hist_idx);
                end else begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                sm.tvalid = 1'b1;
                sm.tdata  = acc;
                sm.tlast  = is_last;
                if (sm.tready) state_nxt = is_last ? S_IDLE : S_WAIT_IN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: BRAM contents are never reset; the CLEAR pass is what zeroes the history.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len       <= '0;
            count     <= '0;
            head      <= '0;
            k         <= '0;
            acc       <= '0;
            ap_done   <= 1'b0;
            err_tlast <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        len       <= data_length;
                        ap_done   <= 1'b0;
                        err_tlast <= 1'b0;
                        k         <= '0;
                    end
                end
                S_CLEAR: begin
                    k     <= k + IDX_W'(1);
                    head  <= '0;
                    count <= '0;
                    if (k == LAST_IDX && len == 32'd0) ap_done <= 1'b1;
                end
                S_WAIT_IN: begin
                    if (ss.tvalid) begin
                        err_tlast <= err_tlast | (ss.tlast != is_last);
                        acc       <= '0;
                        k         <= '0;
                    end
                end
                S_MAC: begin
                    // Low DATA_W bits of the product are identical for signed and unsigned operands.
                    if (k != '0) acc <= acc + tap_Do * data_Do;
                    if (k != MAC_END) k <= k + IDX_W'(1);
                end
                S_OUT: begin
                    if (sm.tready) begin
                        head  <= (head == LAST_IDX) ? '0 : head + IDX_W'(1);
                        count <= count + 32'd1;
                        if (is_last) ap_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_datapath_ctrl.sv
// Bench for fir_datapath_ctrl: BRAM models, a direct-form FIR reference model and directed runs.
module tb_fir_datapath_ctrl;
    localparam int NUM_TAP = 11;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 12;

    logic              axis_clk    = 1'b0;
    logic              axis_rst_n  = 1'b0;
    logic              ap_start    = 1'b0;
    logic [31:0]       data_length = '0;
    logic              ap_idle, ap_done, err_tlast;
    logic              tap_EN, data_EN;
    logic [ADDR_W-1:0] tap_A, data_A;
    logic [3:0]        data_WE;
    logic [DATA_W-1:0] data_Di;
    logic [DATA_W-1:0] tap_Do  = '0;
    logic [DATA_W-1:0] data_Do = '0;

    fir_datapath_ctrl_if #(.DATA_W(DATA_W)) ss ();
    fir_datapath_ctrl_if #(.DATA_W(DATA_W)) sm ();

    fir_datapath_ctrl #(.NUM_TAP(NUM_TAP), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .ap_start(ap_start),
        .data_length(data_length), .ap_idle(ap_idle), .ap_done(ap_done),
        .err_tlast(err_tlast), .ss(ss), .sm(sm),
        .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A),
        .data_Di(data_Di), .data_Do(data_Do)
    );

    always #5 axis_clk = ~axis_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, $signed(got), got,
                     $signed(want), want);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // Synchronous BRAMs, one-cycle read latency.
    logic [DATA_W-1:0] tap_mem  [16];
    logic [DATA_W-1:0] data_mem [16];
    always @(posedge axis_clk) begin
        if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];
        if (data_EN) begin
            if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
            data_Do <= data_mem[data_A[5:2]];
        end
    end

    int taps_c [NUM_TAP] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int t2_exp [11]      = '{0, -10, -29, -25, 35, 158, 337, 539, 732, 915, 1098};
    int cur_x  [64];

    // y[n] = sum_k h[k]*x[n-k], history before the run is zero, 32-bit wrap.
    function automatic logic [31:0] model_y(input int n);
        logic [31:0] s;
        s = '0;
        for (int j = 0; j < NUM_TAP; j++)
            if (n - j >= 0) s = s + 32'(taps_c[j]) * 32'(cur_x[n - j]);
        return s;
    endfunction

    logic [31:0] exp_data_q [$];
    logic        exp_last_q [$];
    logic [31:0] got_q      [$];

    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_last = 1'b0;

    always @(negedge axis_clk) begin
        if (!axis_rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(sm.tvalid), 32'd1);
                check("hold_data", sm.tdata, stall_data);
                check("hold_last", 32'(sm.tlast), 32'(stall_last));
            end
            if (sm.tvalid) check("ss_ready_in_out", 32'(ss.tready), 32'd0);
            if (sm.tvalid && sm.tready) begin
                if (exp_data_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0d with no sample pending",
                             $signed(sm.tdata));
                end else begin
                    check("y_data", sm.tdata, exp_data_q.pop_front());
                    check("y_last", 32'(sm.tlast), 32'(exp_last_q.pop_front()));
                    got_q.push_back(sm.tdata);
                end
            end
            stall_prev = sm.tvalid && !sm.tready;
            stall_data = sm.tdata;
            stall_last = sm.tlast;
        end
    end

    task automatic start_run(input int len);
        data_length = 32'(len);
        ap_start    = 1'b1;
        @(posedge axis_clk); #1;
        ap_start    = 1'b0;
    endtask

    // One full run over cur_x[0..len-1]; optional output stall and early tlast.
    task automatic run_stream(input int len, input int stall_beat, input int early_last);
        int w;
        got_q.delete();
        start_run(len);
        for (int n = 0; n < len; n++) begin
            ss.tvalid = 1'b1;
            ss.tdata  = 32'(cur_x[n]);
            ss.tlast  = (n == len - 1) || (n == early_last);
            sm.tready = (n != stall_beat);
            w = 0;
            while (!ss.tready && w < 100) begin @(posedge axis_clk); #1; w++; end
            if (!ss.tready) begin fail("in_handshake"); ss.tvalid = 1'b0; return; end
            exp_data_q.push_back(model_y(n));
            exp_last_q.push_back(n == len - 1);
            @(posedge axis_clk); #1;
            ss.tvalid = 1'b0;
            ss.tlast  = 1'b0;
            w = 0;
            while (!sm.tvalid && w < 100) begin @(posedge axis_clk); #1; w++; end
            if (!sm.tvalid) begin fail("out_valid"); return; end
            if (n == stall_beat) begin
                data_length = 32'd3;
                ap_start    = 1'b1;
                @(posedge axis_clk); #1;
                ap_start    = 1'b0;
                repeat (4) begin @(posedge axis_clk); #1; end
                sm.tready = 1'b1;
            end
            @(posedge axis_clk); #1;
        end
        w = 0;
        while (!ap_idle && w < 20) begin @(posedge axis_clk); #1; w++; end
        check("run_idle", 32'(ap_idle), 32'd1);
        check("run_done", 32'(ap_done), 32'd1);
        check("run_count", 32'(got_q.size()), 32'(len));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idle"}, 32'(ap_idle), 32'd1);
        check({tag, "_done"}, 32'(ap_done), 32'd0);
        check({tag, "_err"}, 32'(err_tlast), 32'd0);
        check({tag, "_ss_ready"}, 32'(ss.tready), 32'd0);
        check({tag, "_sm_valid"}, 32'(sm.tvalid), 32'd0);
        check({tag, "_sm_data"}, sm.tdata, 32'd0);
        check({tag, "_bram_en"}, 32'({tap_EN, data_EN, data_WE}), 32'd0);
        check({tag, "_bram_addr"}, 32'({tap_A, data_A}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, we_cnt;
        logic saw_rdy, saw_vld;
        ss.tvalid = 1'b0;
        ss.tdata  = '0;
        ss.tlast  = 1'b0;
        sm.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tap_mem[i]  = (i < NUM_TAP) ? 32'(taps_c[i]) : '0;
            data_mem[i] = 32'hDEAD_0000 + 32'(i);
        end

        #23;
        check_reset_outputs("reset");
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;

        // T1: impulse response reproduces the taps in order
        for (int i = 0; i < 11; i++) cur_x[i] = (i == 0) ? 1 : 0;
        run_stream(11, -1, -1);
        for (int i = 0; i < 11 && i < got_q.size(); i++)
            check("t1_impulse", got_q[i], 32'(taps_c[i]));

        // T2: ramp input against hand-computed outputs
        for (int i = 0; i < 11; i++) cur_x[i] = i + 1;
        run_stream(11, -1, -1);
        for (int i = 0; i < 11 && i < got_q.size(); i++)
            check("t2_ramp", got_q[i], 32'(t2_exp[i]));
        check("t2_err", 32'(err_tlast), 32'd0);

        // T3: output back-pressure on beat 2, plus a start pulse that must be ignored
        cur_x[0] = 4; cur_x[1] = -3; cur_x[2] = 8; cur_x[3] = 100;
        run_stream(4, 2, -1);

        // T4: zero-length run only clears the history
        start_run(0);
        we_cnt  = 0;
        saw_rdy = 1'b0;
        saw_vld = 1'b0;
        w = 0;
        while (!ap_done && w < 40) begin
            if (data_EN && data_WE == 4'hF && data_Di == '0) we_cnt++;
            saw_rdy |= ss.tready;
            saw_vld |= sm.tvalid;
            @(posedge axis_clk); #1;
            w++;
        end
        check("t4_clear_writes", 32'(we_cnt), 32'(NUM_TAP));
        check("t4_ss_ready", 32'(saw_rdy), 32'd0);
        check("t4_sm_valid", 32'(saw_vld), 32'd0);
        check("t4_done", 32'(ap_done), 32'd1);
        check("t4_idle", 32'(ap_idle), 32'd1);
        for (int i = 0; i < NUM_TAP; i++) check("t4_hist_zero", data_mem[i], 32'd0);

        // T5: 15 samples (head wraps), early tlast on beat 3
        for (int i = 0; i < 15; i++) cur_x[i] = (i + 1) * 37 - 200;
        run_stream(15, -1, 2);
        check("t5_err", 32'(err_tlast), 32'd1);

        // T6: reset during MAC, then a short clean run
        cur_x[0] = 9;
        start_run(11);
        ss.tvalid = 1'b1;
        ss.tdata  = 32'd9;
        w = 0;
        while (!ss.tready && w < 40) begin @(posedge axis_clk); #1; w++; end
        if (!ss.tready) fail("t6_in_handshake");
        @(posedge axis_clk); #1;
        ss.tvalid = 1'b0;
        repeat (3) begin @(posedge axis_clk); #1; end
        axis_rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        exp_data_q.delete();
        exp_last_q.delete();
        repeat (2) begin @(posedge axis_clk); #1; end
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        cur_x[0] = 5; cur_x[1] = 7;
        run_stream(2, -1, -1);
        if (got_q.size() == 2) begin
            check("t6_y0", got_q[0], 32'd0);
            check("t6_y1", got_q[1], -32'sd50);
        end
        check("t6_err", 32'(err_tlast), 32'd0);

        repeat (3) @(posedge axis_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
